mem_arbiter: RTL and testbench

//  Single-port RAM arbiter directly downstream of icache and dcache.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: word type, RAM handshake
// states reported by the memory, and the arbiter FSM state encoding.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM for the access currently presented to it.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM encoding.
  typedef logic [1:0] arb_state_t;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter between icache and dcache for a single shared RAM port.
// The data side has priority; a saturating streak counter forces an
// instruction grant after MAX_DSTREAK back-to-back data completions that
// happened while an instruction fetch was waiting.
//
// Handshake: each cache holds its request level (and address/data stable)
// until it sees its wait signal low for one cycle; that cycle is the
// completion and carries the load data. Dropping the request while granted
// aborts the access with no wait pulse. The RAM completes an access in the
// cycle it reports ACCESS; BUSY, FREE and ERROR hold the access in place.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  localparam int SW = $clog2(MAX_DSTREAK + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  // instruction side
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  // data side
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  // RAM side
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  ramstate_t  ramstate,
  // debug visibility of arbiter state
  output arb_state_t fsm_state,
  output logic [SW-1:0] dstreak
);

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    state;
  arb_state_t    state_next;
  logic [SW-1:0] streak;
  logic          d_req;
  logic          i_done;
  logic          d_done;

  assign d_req     = dREN | dWEN;
  assign fsm_state = state;
  assign dstreak   = streak;

  // Next-state selection and all combinational outputs, including the
  // same-cycle completion pulse when the RAM reports ACCESS.
  always_comb begin
    state_next = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless the instruction side has already waited out a
        // full streak of data completions.
        if (d_req && (streak < STREAK_MAX || !iREN)) begin
          state_next = DGRANT;
        end else if (iREN) begin
          state_next = IGRANT;
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            i_done     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DGRANT: begin
        if (!d_req) begin
          state_next = IDLE;
        end else begin
          ramaddr  = daddr;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramstore = dstore;
          if (ramstate == ACCESS) begin
            dwait      = 1'b0;
            dload      = dWEN ? '0 : ramload;
            d_done     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Data-completion streak seen by a waiting fetch; cleared whenever the
  // fetch is not pending or has just been served.
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak <= '0;
    end else if (!iREN || i_done) begin
      streak <= '0;
    end else if (d_done && streak < STREAK_MAX) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cache-side drivers, a behavioural
// RAM responder, a memory-content reference model feeding per-side
// expectation queues, and a monitor that checks grant order and completions.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAX_DSTREAK = 4;
  localparam int BUDGET      = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore, ram_load;
  ramstate_t   ram_state;
  logic [1:0]  fsm_state;
  logic [2:0]  dstreak;

  mem_arbiter #(.MAX_DSTREAK(MAX_DSTREAK)) dut (
    .CLK(clk), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ram_load), .ramstate(ram_state),
    .fsm_state(fsm_state), .dstreak(dstreak)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial RAM contents, shared definition for RAM and reference model.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model_mem [logic [31:0]];
  logic [63:0] i_exp_q [$];   // {addr, data}
  logic [64:0] d_exp_q [$];   // {is_write, addr, data}

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  // ---------------- RAM responder ----------------
  logic [31:0] ram_mem [logic [31:0]];
  int  fixed_lat = -1;   // -1: random latency 0..3
  int  wait_code = -1;   // -1: random FREE/BUSY/ERROR while waiting
  bit  busy = 1'b0;
  int  lat = 0;

  initial begin
    ram_state = FREE;
    ram_load  = '0;
  end

  // Responds shortly after each edge, once the DUT's enables have settled.
  always @(posedge clk) begin : responder
    int r;
    #2;
    if (!RST && (ramREN || ramWEN)) begin
      if (!busy) begin
        busy = 1'b1;
        lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (lat == 0) begin
        busy      = 1'b0;
        ram_state = ACCESS;
        if (ramWEN) begin
          ram_mem[ramaddr] = ramstore;
          ram_load = $urandom;
        end else begin
          ram_load = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_word(ramaddr);
        end
      end else begin
        lat--;
        r = int'($urandom_range(0, 2));
        if (wait_code >= 0) ram_state = ramstate_t'(wait_code[1:0]);
        else ram_state = (r == 2) ? ERROR : ramstate_t'(r[1:0]);
        ram_load = $urandom;
      end
    end else begin
      busy      = 1'b0;
      ram_state = FREE;
      ram_load  = $urandom;
    end
  end

  // ---------------- monitor ----------------
  int  cnt = 0;            // D completions while a fetch keeps waiting
  bit  in_grant = 1'b0;
  bit  prev_rst = 1'b1, prev_en = 1'b0, prev_dreq = 1'b0, prev_iren = 1'b0;

  always @(negedge clk) begin : monitor
    logic en, dreq, exp_d;
    logic [63:0] ie;
    logic [64:0] de;
    logic [31:0] exp_addr;
    en   = ramREN | ramWEN;
    dreq = dREN | dWEN;
    if (RST) begin
      cnt      = 0;
      in_grant = 1'b0;
    end else begin
      // a pending request seen in an idle cycle must be granted next cycle
      if (!prev_rst && !prev_en && (prev_dreq || prev_iren)) begin
        exp_d    = prev_dreq && (cnt < MAX_DSTREAK || !prev_iren);
        exp_addr = exp_d ? daddr : iaddr;
        chk(en, "grant_latency", 64'(en), 64'd1);
        chk(ramaddr == exp_addr, "grant_order", 64'(ramaddr), 64'(exp_addr));
        in_grant = en;
      end else if (!prev_rst && !prev_en) begin
        chk(!en, "spurious_grant", 64'(en), 64'd0);
      end else if (in_grant) begin
        chk(en, "enables_held", 64'(en), 64'd1);
      end
      if (!en) begin
        chk(iwait && dwait, "idle_waits", 64'({iwait, dwait}), 64'b11);
        chk((iload | dload | ramstore | ramaddr) == 0, "idle_buses",
            {ramaddr, iload | dload | ramstore}, 64'd0);
      end
      chk(dstreak == 3'(cnt), "streak", 64'(dstreak), 64'(cnt));
      if (!iwait) begin
        chk(i_exp_q.size() > 0, "i_pulse_expected", 64'(i_exp_q.size()), 64'd1);
        chk(dwait, "dwait_during_i", 64'(dwait), 64'd1);
        if (i_exp_q.size() > 0) begin
          ie = i_exp_q.pop_front();
          chk(ramREN && !ramWEN && ramaddr == ie[63:32], "i_access",
              {ramaddr, 30'd0, ramREN, ramWEN}, {ie[63:32], 32'd2});
          chk(iload == ie[31:0], "iload", 64'(iload), 64'(ie[31:0]));
        end
      end
      if (!dwait) begin
        chk(d_exp_q.size() > 0, "d_pulse_expected", 64'(d_exp_q.size()), 64'd1);
        chk(iwait, "iwait_during_d", 64'(iwait), 64'd1);
        if (d_exp_q.size() > 0) begin
          de = d_exp_q.pop_front();
          chk(ramaddr == de[63:32] && ramWEN == de[64] && ramREN == !de[64], "d_access",
              {ramaddr, 30'd0, ramREN, ramWEN}, {de[63:32], 30'd0, !de[64], de[64]});
          if (de[64]) begin
            chk(ramstore == de[31:0], "ramstore", 64'(ramstore), 64'(de[31:0]));
            chk(dload == 0, "dload_write", 64'(dload), 64'd0);
          end else begin
            chk(dload == de[31:0], "dload", 64'(dload), 64'(de[31:0]));
          end
        end
      end
      if (!iREN || !iwait) cnt = 0;
      else if (!dwait && cnt < MAX_DSTREAK) cnt++;
      if (!iwait || !dwait) in_grant = 1'b0;
    end
    prev_rst  = RST;
    prev_en   = en;
    prev_dreq = dreq;
    prev_iren = iREN;
  end

  // ---------------- driver tasks ----------------
  task automatic do_i(input logic [31:0] a);
    int n;
    @(posedge clk); #1;
    iREN  = 1'b1;
    iaddr = a;
    i_exp_q.push_back({a, model_word(a)});
    n = 0;
    do begin @(negedge clk); n++; end while (iwait && n < BUDGET);
    chk(!iwait, "i_complete_in_budget", 64'(n), 64'(BUDGET));
    if (iwait) begin
      i_exp_q.delete();
      @(posedge clk); #1;
      iREN = 1'b0;
    end
  endtask

  task automatic do_d(input logic [31:0] a, input bit we, input bit ren_too,
                      input logic [31:0] data);
    int n;
    @(posedge clk); #1;
    daddr  = a;
    dWEN   = we;
    dREN   = we ? ren_too : 1'b1;
    dstore = we ? data : $urandom;
    if (we) begin
      model_mem[a] = data;
      d_exp_q.push_back({1'b1, a, data});
    end else begin
      d_exp_q.push_back({1'b0, a, model_word(a)});
    end
    n = 0;
    do begin @(negedge clk); n++; end while (dwait && n < BUDGET);
    chk(!dwait, "d_complete_in_budget", 64'(n), 64'(BUDGET));
    if (dwait) begin
      d_exp_q.delete();
      @(posedge clk); #1;
      dREN = 1'b0;
      dWEN = 1'b0;
    end
  endtask

  task automatic i_gap(input int n);
    if (n > 0) begin
      @(posedge clk); #1;
      iREN = 1'b0;
      repeat (n - 1) @(posedge clk);
    end
  endtask

  task automatic d_gap(input int n);
    if (n > 0) begin
      @(posedge clk); #1;
      dREN = 1'b0;
      dWEN = 1'b0;
      repeat (n - 1) @(posedge clk);
    end
  endtask

  function automatic logic [31:0] rand_iaddr();
    return 32'h1000 + 32'(4 * $urandom_range(0, 63));
  endfunction

  function automatic logic [31:0] rand_daddr();
    return 32'h100 + 32'(4 * $urandom_range(0, 15));
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(fsm_state == IDLE && dstreak == 0, "reset_state",
        64'({fsm_state, dstreak}), 64'd0);
    chk(!ramREN && !ramWEN && iwait && dwait, "reset_ctrl",
        64'({ramREN, ramWEN, iwait, dwait}), 64'b0011);
    chk((ramaddr | ramstore | iload | dload) == 0, "reset_buses",
        64'(ramaddr | ramstore | iload | dload), 64'd0);
    @(posedge clk); #1;
    RST = 1'b0;

    // fetch completing on the second grant cycle
    fixed_lat = 1;
    do_i(32'h40);
    i_gap(1);

    // simultaneous requests: data first, fetch after one bubble
    fixed_lat = -1;
    fork
      begin do_d(32'h100, 1'b0, 1'b0, '0); d_gap(1); end
      begin do_i(32'h1040); i_gap(1); end
    join
    i_gap(2);

    // write with both enables, then read it back
    do_d(32'h200, 1'b1, 1'b1, 32'hDEAD_BEEF);
    d_gap(1);
    do_d(32'h200, 1'b0, 1'b0, '0);
    d_gap(1);

    // ERROR for three cycles before ACCESS
    fixed_lat = 3; wait_code = int'(ERROR);
    do_d(32'h104, 1'b0, 1'b0, '0);
    d_gap(1);
    fixed_lat = -1; wait_code = -1;

    // continuous data stream against a continuously waiting fetch
    fixed_lat = 0;
    fork
      begin repeat (3) do_i(rand_iaddr()); i_gap(1); end
      begin repeat (14) do_d(rand_daddr(), 1'b0, 1'b0, '0); d_gap(1); end
    join
    fixed_lat = -1;
    i_gap(2);

    // reset while a data access sits in BUSY
    fixed_lat = 1000; wait_code = int'(BUSY);
    @(posedge clk); #1;
    dREN = 1'b1; daddr = 32'h300;
    repeat (2) @(negedge clk);
    chk(ramREN && ramaddr == 32'h300, "pre_reset_grant",
        {ramaddr, 31'd0, ramREN}, {32'h300, 32'd1});
    @(posedge clk); #1;
    RST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(fsm_state == IDLE && dstreak == 0, "midreset_state",
        64'({fsm_state, dstreak}), 64'd0);
    chk(!ramREN && !ramWEN && iwait && dwait, "midreset_ctrl",
        64'({ramREN, ramWEN, iwait, dwait}), 64'b0011);
    @(posedge clk); #1;
    RST = 1'b0; dREN = 1'b0;
    fixed_lat = -1; wait_code = -1;
    i_gap(2);

    // randomized traffic on both sides
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          do_i(rand_iaddr());
          i_gap(int'($urandom_range(0, 3)));
        end
        i_gap(1);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          do_d(rand_daddr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
          d_gap(int'($urandom_range(0, 2)));
        end
        d_gap(1);
      end
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(i_exp_q.size() == 0 && d_exp_q.size() == 0, "queues_drained",
        64'(i_exp_q.size() + d_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
